// File: rtl/audio_in.sv
// I2S slave capture core: codec ADC samples into left/right ring buffers read over the port bus.
// Define AUDIO_IN_LJ_EN for left-justified framing (lr_clk = 1 is left, no 1-bit delay).
`timescale 1ns/1ps
module audio_in #(
    parameter int BITS             = 16,
    parameter int ADDRESS_BITS     = 12,
    parameter int BUF_ADDRESS_BITS = 9
) (
    input  logic                    CLK,
    input  logic                    RSTb,
    input  logic [ADDRESS_BITS-1:0] ADDRESS,
    input  logic [BITS-1:0]         DATA_IN,
    output logic [BITS-1:0]         DATA_OUT,
    input  logic                    WR,
    output logic                    mclk,
    input  logic                    sclk,
    input  logic                    lr_clk,
    input  logic                    sdat,
    output logic                    irq
);
    localparam int DEPTH = 1 << BUF_ADDRESS_BITS;
    localparam logic [5:0] CNT_FULL = 6'(BITS);
    localparam logic [5:0] CNT_IDLE = 6'd63;
    localparam logic [BUF_ADDRESS_BITS-1:0] PTR_ONE = BUF_ADDRESS_BITS'(1);

    logic [1:0] sclk_sync, lr_sync, sd_sync;
    logic sclk_d, sclk_rise, lr, sd;

    logic [5:0] bit_cnt;
    logic [BITS-1:0] shift, word_next, start_shift;
    logic lr_prev, chan, start_chan, armed, boundary;
    logic wr_pend, wr_chan, wr_go;
    logic [BITS-1:0] wr_data;

    logic control_run;
    logic [BUF_ADDRESS_BITS-1:0] left_wr_ptr, right_wr_ptr;
    logic [BITS-1:0] left_mem [DEPTH];
    logic [BITS-1:0] right_mem [DEPTH];

    logic unused_data_in;

    assign mclk = CLK;
    assign unused_data_in = ^DATA_IN[BITS-1:1];

    assign sclk_rise = sclk_sync[1] & ~sclk_d;
    assign lr        = lr_sync[1];
    assign sd        = sd_sync[1];
    assign boundary  = (lr != lr_prev);
    assign word_next = {shift[BITS-2:0], sd};

`ifdef AUDIO_IN_LJ_EN
    localparam logic [5:0] CNT_START = 6'd1;
    assign start_chan  = ~lr;
    assign start_shift = {{(BITS-1){1'b0}}, sd};
`else
    localparam logic [5:0] CNT_START = 6'd0;
    assign start_chan  = lr;
    assign start_shift = shift;
`endif

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            sclk_sync <= '0;
            lr_sync   <= '0;
            sd_sync   <= '0;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk};
            lr_sync   <= {lr_sync[0], lr_clk};
            sd_sync   <= {sd_sync[0], sdat};
            sclk_d    <= sclk_sync[1];
        end
    end

    // Bit counter idles at 63 until a word boundary, so a word entered mid-stream is never committed.
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            bit_cnt <= CNT_IDLE;
            shift   <= '0;
            lr_prev <= 1'b0;
            chan    <= 1'b0;
            armed   <= 1'b0;
            wr_pend <= 1'b0;
            wr_chan <= 1'b0;
            wr_data <= '0;
        end else begin
            wr_pend <= 1'b0;
            if (!control_run)
                armed <= 1'b0;
            if (sclk_rise) begin
                lr_prev <= lr;
                if (boundary) begin
                    bit_cnt <= CNT_START;
                    chan    <= start_chan;
                    shift   <= start_shift;
                    if (control_run)
                        armed <= 1'b1;
                end else if (bit_cnt < CNT_FULL) begin
                    shift   <= word_next;
                    bit_cnt <= bit_cnt + 6'd1;
                    if (bit_cnt == CNT_FULL - 6'd1 && control_run && armed) begin
                        wr_pend <= 1'b1;
                        wr_chan <= chan;
                        wr_data <= word_next;
                    end
                end else begin
                    bit_cnt <= CNT_IDLE;
                end
            end
        end
    end

    // A pending word is dropped if run was cleared in the meantime, so pointers and irq stay frozen.
    assign wr_go = wr_pend & control_run & RSTb;

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            left_wr_ptr  <= '0;
            right_wr_ptr <= '0;
            irq          <= 1'b0;
        end else begin
            irq <= wr_go & wr_chan & (&right_wr_ptr[BUF_ADDRESS_BITS-2:0]);
            if (wr_go) begin
                if (wr_chan)
                    right_wr_ptr <= right_wr_ptr + PTR_ONE;
                else
                    left_wr_ptr <= left_wr_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_go) begin
            if (wr_chan)
                right_mem[right_wr_ptr] <= wr_data;
            else
                left_mem[left_wr_ptr] <= wr_data;
        end
    end

    // Reads sample the arrays before this edge's capture write lands, giving old data on a collision.
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            control_run <= 1'b0;
            DATA_OUT    <= '0;
        end else begin
            if (WR && ADDRESS == 12'h400)
                control_run <= DATA_IN[0];
            casez (ADDRESS)
                12'b000?_????_????: DATA_OUT <= left_mem[ADDRESS[BUF_ADDRESS_BITS-1:0]];
                12'b001?_????_????: DATA_OUT <= right_mem[ADDRESS[BUF_ADDRESS_BITS-1:0]];
                12'h400:            DATA_OUT <= {{(BITS-1){1'b0}}, control_run};
                12'h401:            DATA_OUT <= {{(BITS-BUF_ADDRESS_BITS){1'b0}}, left_wr_ptr};
                12'h402:            DATA_OUT <= {{(BITS-BUF_ADDRESS_BITS){1'b0}}, right_wr_ptr};
                default:            DATA_OUT <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_audio_in.sv
// Directed bench for audio_in: register table, arming, run clear, irq at half-buffer, reset, framing.
// Follows AUDIO_IN_LJ_EN so the same bench covers both framing builds.
`timescale 1ns/1ps
module tb_audio_in;
    logic CLK, RSTb, WR, mclk, sclk, lr_clk, sdat, irq;
    logic [11:0] ADDRESS;
    logic [15:0] DATA_IN, DATA_OUT;

    int check_count = 0;
    int pass_count  = 0;
    int irq_count   = 0;

`ifdef AUDIO_IN_LJ_EN
    localparam logic LEFT_LR = 1'b1;
    localparam int WORD_RISES = 16;
`else
    localparam logic LEFT_LR = 1'b0;
    localparam int WORD_RISES = 17;
`endif
    localparam logic RIGHT_LR = ~LEFT_LR;

    typedef struct {
        logic [11:0] addr;
        logic        wr;
        logic [15:0] wdata;
        logic        chk;
        logic [15:0] exp;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    audio_in dut (
        .CLK(CLK), .RSTb(RSTb), .ADDRESS(ADDRESS), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT),
        .WR(WR), .mclk(mclk), .sclk(sclk), .lr_clk(lr_clk), .sdat(sdat), .irq(irq)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK)
        if (irq === 1'b1)
            irq_count <= irq_count + 1;

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [11:0] a, input logic w, input logic [15:0] d);
        @(negedge CLK);
        ADDRESS = a;
        WR      = w;
        DATA_IN = d;
        @(negedge CLK);
        WR = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        check_count++;
        if (actual === expected)
            pass_count++;
        else
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic check_port(input string name, input logic [11:0] a, input logic [15:0] expected);
        applyStimulus(a, 1'b0, 16'h0);
        checkOutput(name, DATA_OUT, expected);
    endtask

    task automatic set_run(input logic v);
        applyStimulus(12'h400, 1'b1, {15'd0, v});
    endtask

    task automatic settle();
        repeat (8) @(negedge CLK);
    endtask

    // Codec side: data changes while sclk is low, receiver samples on the rise (period = 8 CLK).
    task automatic send_rise(input logic lr_v, input logic sd_v);
        lr_clk = lr_v;
        sdat   = sd_v;
        repeat (4) @(negedge CLK);
        sclk = 1'b1;
        repeat (4) @(negedge CLK);
        sclk = 1'b0;
    endtask

    function automatic logic slot_bit(input logic [15:0] w, input int k);
`ifdef AUDIO_IN_LJ_EN
        if (k < 16) return w[15-k];
`else
        if (k >= 1 && k <= 16) return w[16-k];
`endif
        return 1'b0;
    endfunction

    task automatic send_slot(input logic lr_v, input logic [15:0] w, input int from, input int upto);
        for (int k = from; k < upto; k++)
            send_rise(lr_v, slot_bit(w, k));
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_slot(LEFT_LR, l, 0, 32);
        send_slot(RIGHT_LR, r, 0, 32);
    endtask

    // Minimal frame: one left rise only to flip lr, then just enough right rises to commit.
    task automatic send_short_frame(input logic [15:0] r);
        send_slot(LEFT_LR, 16'h0, 0, 1);
        send_slot(RIGHT_LR, r, 0, WORD_RISES);
    endtask

    initial begin
        vecs[0]  = '{12'h400, 1'b0, 16'h0000, 1'b1, 16'h0000};
        vecs[1]  = '{12'h401, 1'b0, 16'h0000, 1'b1, 16'h0000};
        vecs[2]  = '{12'h402, 1'b0, 16'h0000, 1'b1, 16'h0000};
        vecs[3]  = '{12'h401, 1'b1, 16'hFFFF, 1'b0, 16'h0000};
        vecs[4]  = '{12'h401, 1'b0, 16'h0000, 1'b1, 16'h0000};
        vecs[5]  = '{12'h402, 1'b1, 16'h1234, 1'b0, 16'h0000};
        vecs[6]  = '{12'h402, 1'b0, 16'h0000, 1'b1, 16'h0000};
        vecs[7]  = '{12'h403, 1'b0, 16'h0000, 1'b1, 16'h0000};
        vecs[8]  = '{12'hFFF, 1'b0, 16'h0000, 1'b1, 16'h0000};
        vecs[9]  = '{12'h400, 1'b1, 16'hFFFE, 1'b0, 16'h0000};
        vecs[10] = '{12'h400, 1'b0, 16'h0000, 1'b1, 16'h0000};
        vecs[11] = '{12'h400, 1'b1, 16'h0001, 1'b0, 16'h0000};
        vecs[12] = '{12'h400, 1'b0, 16'h0000, 1'b1, 16'h0001};
        vecs[13] = '{12'h400, 1'b1, 16'h0000, 1'b0, 16'h0000};
        vecs[14] = '{12'h400, 1'b0, 16'h0000, 1'b1, 16'h0000};

        RSTb = 1'b0; WR = 1'b0; ADDRESS = '0; DATA_IN = '0;
        sclk = 1'b0; lr_clk = 1'b0; sdat = 1'b0;
        repeat (5) @(negedge CLK);
        RSTb = 1'b1;
        $display("[TB] reset released, register table");

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].addr, vecs[i].wr, vecs[i].wdata);
            if (vecs[i].chk)
                checkOutput($sformatf("vec%0d addr %h", i, vecs[i].addr), DATA_OUT, vecs[i].exp);
        end

        repeat (1000) @(negedge CLK);
        checkOutput("irq idle", 16'(irq_count), 16'd0);

        $display("[TB] arming");
        send_frame(16'h1111, 16'h2222);
        send_slot(LEFT_LR, 16'h3333, 0, 32);
        send_slot(RIGHT_LR, 16'h4444, 0, 10);
        set_run(1'b1);
        send_slot(RIGHT_LR, 16'h4444, 10, 32);
        send_frame(16'hA5C3, 16'h1234);
        settle();
        check_port("left[0]", 12'h000, 16'hA5C3);
        check_port("right[0]", 12'h200, 16'h1234);
        check_port("left ptr arm", 12'h401, 16'd1);
        check_port("right ptr arm", 12'h402, 16'd1);

        $display("[TB] run clear mid-word");
        send_slot(LEFT_LR, 16'hBEEF, 0, 8);
        set_run(1'b0);
        send_slot(LEFT_LR, 16'hBEEF, 8, 32);
        settle();
        check_port("left ptr at clear", 12'h401, 16'd1);
        send_slot(RIGHT_LR, 16'hBEEF, 0, 32);
        send_frame(16'hDEAD, 16'hDEAD);
        send_frame(16'hDEAD, 16'hDEAD);
        send_frame(16'hDEAD, 16'hDEAD);
        settle();
        check_port("right ptr stopped", 12'h402, 16'd1);
        set_run(1'b1);
        send_frame(16'hCAFE, 16'hF00D);
        settle();
        check_port("left[1] rearm", 12'h001, 16'hCAFE);
        check_port("right[1] rearm", 12'h201, 16'hF00D);
        check_port("left[0] kept", 12'h000, 16'hA5C3);
        check_port("left ptr rearm", 12'h401, 16'd2);
        check_port("right ptr rearm", 12'h402, 16'd2);

        $display("[TB] half-buffer irq");
        for (int idx = 2; idx < 255; idx++)
            send_short_frame(16'h8000 ^ 16'(idx));
        settle();
        checkOutput("irq before 256", 16'(irq_count), 16'd0);
        check_port("right ptr 255", 12'h402, 16'd255);
        send_short_frame(16'h8000 ^ 16'd255);
        settle();
        checkOutput("irq at 256", 16'(irq_count), 16'd1);
        check_port("right ptr 256", 12'h402, 16'd256);
        for (int idx = 256; idx < 512; idx++)
            send_short_frame(16'h8000 ^ 16'(idx));
        settle();
        checkOutput("irq at wrap", 16'(irq_count), 16'd2);
        check_port("right ptr wrap", 12'h402, 16'd0);
        check_port("right[300]", 12'h200 + 12'd300, 16'h812C);
        check_port("left ptr held", 12'h401, 16'd2);
        send_short_frame(16'h5A5A);
        settle();
        check_port("right[0] overwrite", 12'h200, 16'h5A5A);
        check_port("right ptr after wrap", 12'h402, 16'd1);

        $display("[TB] reset mid-word");
        send_slot(LEFT_LR, 16'h7777, 0, 8);
        @(negedge CLK);
        RSTb = 1'b0;
        repeat (3) @(negedge CLK);
        RSTb = 1'b1;
        check_port("run after reset", 12'h400, 16'd0);
        check_port("left ptr reset", 12'h401, 16'd0);
        check_port("right ptr reset", 12'h402, 16'd0);
        send_slot(LEFT_LR, 16'h7777, 8, 32);
        send_slot(RIGHT_LR, 16'h7777, 0, 32);
        set_run(1'b1);
        send_frame(16'h1357, 16'h2468);
        settle();
        check_port("left[0] after reset", 12'h000, 16'h1357);
        check_port("right[0] after reset", 12'h200, 16'h2468);
        check_port("left ptr after reset", 12'h401, 16'd1);
        check_port("right ptr after reset", 12'h402, 16'd1);

        $display("[TB] left-justified stimulus 8001");
        send_rise(1'b0, 1'b0);
        for (int k = 0; k < 32; k++)
            send_rise(1'b1, (k == 0 || k == 15));
        send_rise(1'b0, 1'b0);
        settle();
`ifdef AUDIO_IN_LJ_EN
        check_port("lj left[1]", 12'h001, 16'h8001);
        check_port("lj left ptr", 12'h401, 16'd2);
`else
        check_port("i2s right[1]", 12'h201, 16'h0002);
        check_port("i2s right ptr", 12'h402, 16'd2);
`endif
        checkOutput("irq total", 16'(irq_count), 16'd2);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
